// File: rtl/mux_demux_pkg.sv
// Shared definitions for the 4:1 round-robin mux and its 1:4 demux counterpart.
// Channel count, tag width and the tag type live here so both sides agree.
package mux_demux_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Channel visited 'step' positions after 'base' in the circular search order.
  function automatic sel_t rr_offset(input sel_t base, input int step);
    rr_offset = base + sel_t'(step);
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter.
// The search starts one past 'last' and wraps, so 'last' itself has the lowest priority.
module rr_arbiter4
  import mux_demux_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  sel_t           last,
  output logic [NCH-1:0] grant,
  output sel_t           gnt_idx,
  output logic           any
);

  sel_t cand;

  always_comb begin
    grant   = '0;
    gnt_idx = last;
    any     = 1'b0;
    cand    = last;
    for (int i = 1; i <= NCH; i++) begin
      cand = rr_offset(last, i);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        gnt_idx     = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_1_rr.sv
// Four-input round-robin stream merge with a one-entry registered output.
// Each output word is tagged with its source channel on 'sel'.
module mux4_1_rr
  import mux_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic             V0,
  input  logic             V1,
  input  logic             V2,
  input  logic             V3,
  output logic             R0,
  output logic             R1,
  output logic             R2,
  output logic             R3,
  output logic [WIDTH-1:0] Y,
  output logic [1:0]       sel,
  output logic             y_valid,
  input  logic             y_ready
);

  logic [WIDTH-1:0] y_p1;
  sel_t             sel_p1;
  logic             vld_p1;
  sel_t             last;

  logic [NCH-1:0]   req;
  logic [NCH-1:0]   grant;
  sel_t             gnt_idx;
  logic             any;
  logic             load;
  logic [NCH-1:0]   rdy;
  logic [WIDTH-1:0] d_pick;

  // ---- stage 0: arbitration and input selection (combinational) ----
  assign req = {V3, V2, V1, V0};

  rr_arbiter4 u_arb (
    .req     (req),
    .last    (last),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign load = !vld_p1 || y_ready;
  // Ready depends only on valids, y_ready and state, never on the data.
  assign rdy  = (rst_n && load) ? grant : '0;

  assign R0 = rdy[0];
  assign R1 = rdy[1];
  assign R2 = rdy[2];
  assign R3 = rdy[3];

  always_comb begin
    d_pick = D0;
    case (gnt_idx)
      2'd0:    d_pick = D0;
      2'd1:    d_pick = D1;
      2'd2:    d_pick = D2;
      default: d_pick = D3;
    endcase
  end

  // ---- stage 1: output register and round-robin pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p1   <= '0;
      sel_p1 <= '0;
      vld_p1 <= 1'b0;
      last   <= 2'b11;
    end else if (load) begin
      if (any) begin
        y_p1   <= d_pick;
        sel_p1 <= gnt_idx;
        vld_p1 <= 1'b1;
        last   <= gnt_idx;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign Y       = y_p1;
  assign sel     = sel_p1;
  assign y_valid = vld_p1;

  a_one_ready : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rdy));

endmodule
